smpl_queue: RTL and testbench



---
 rtl/smpl_queue_pkg.sv | 14 +
 rtl/dp_ram_smpl.sv | 30 +++
 rtl/smpl_queue.sv | 125 ++++++++++++
 tb/tb_smpl_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/smpl_queue_pkg.sv
// Shared types and default sizing for the sample queue.
package smpl_queue_pkg;

    typedef enum logic {IDLE, SEQ} state_t;

    localparam int unsigned DEF_DEPTH  = 1024;
    localparam int unsigned DEF_RD_LEN = 1021;
    localparam int unsigned DEF_W      = 24;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dp_ram_smpl.sv
// Simple dual-port sample RAM: synchronous write, registered read, no array reset.
module dp_ram_smpl #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 48
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/smpl_queue.sv
// Circular stereo sample buffer; each write past the fill level streams the
// newest RD_LEN samples, oldest first, one per clk.
module smpl_queue
    import smpl_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned RD_LEN = DEF_RD_LEN,
    parameter int unsigned W      = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wrt_smpl,
    input  logic [W-1:0] lft_in,
    input  logic [W-1:0] rght_in,
    output logic [W-1:0] lft_out,
    output logic [W-1:0] rght_out,
    output logic         sequencing,
    output logic         drop_err
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] RD_LEN_P  = PTR_W'(RD_LEN);
    localparam logic [PTR_W-1:0] RD_LEN_M1 = PTR_W'(RD_LEN - 1);

    state_t           state, nxt_state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] fill_cnt;
    logic [PTR_W-1:0] rd_addr;
    logic [PTR_W-1:0] rd_cnt;
    logic             rd_en;
    logic             rd_vld;
    logic             trigger;
    logic             last_rd;
    logic             drop;
    logic [2*W-1:0]   ram_dout;

    // Compared against RD_LEN-1 so the post-write count never overflows PTR_W.
    assign trigger = wrt_smpl && (state == IDLE) && (fill_cnt >= RD_LEN_M1);
    assign last_rd = (state == SEQ) && (rd_cnt == RD_LEN_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (trigger) nxt_state = SEQ;
            SEQ:     if (last_rd) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        rd_en = (state == SEQ);
        drop  = wrt_smpl && (state == SEQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            drop_err <= 1'b0;
        end else begin
            if (wrt_smpl) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (fill_cnt != RD_LEN_P) begin
                    fill_cnt <= fill_cnt + PTR_W'(1);
                end
            end
            if (drop) begin
                drop_err <= 1'b1;
            end
        end
    end

    // Window start is captured from the pointer of the triggering write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
            rd_cnt  <= '0;
        end else if (trigger) begin
            rd_addr <= wr_ptr - RD_LEN_M1;
            rd_cnt  <= '0;
        end else if (rd_en) begin
            rd_addr <= rd_addr + PTR_W'(1);
            rd_cnt  <= rd_cnt + PTR_W'(1);
        end
    end

    dp_ram_smpl #(
        .DEPTH (DEPTH),
        .AW    (PTR_W),
        .DW    (2 * W)
    ) u_ram (
        .clk   (clk),
        .we    (wrt_smpl),
        .waddr (wr_ptr),
        .wdata ({lft_in, rght_in}),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld     <= 1'b0;
            sequencing <= 1'b0;
            lft_out    <= '0;
            rght_out   <= '0;
        end else begin
            rd_vld     <= rd_en;
            sequencing <= rd_vld;
            if (rd_vld) begin
                lft_out  <= ram_dout[2*W-1:W];
                rght_out <= ram_dout[W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_smpl_queue.sv
// Directed bench for smpl_queue: small ring (DEPTH=8, RD_LEN=5) plus default sizing.
module tb_smpl_queue;

    localparam int unsigned SW = 24;

    typedef struct {
        logic [SW-1:0] val;
        logic          streams;
        logic [SW-1:0] first;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          wr_s, wr_d;
    logic [SW-1:0] lin_s, rin_s, lin_d, rin_d;
    logic [SW-1:0] lout_s, rout_s, lout_d, rout_d;
    logic          seq_s, seq_d, derr_s, derr_d;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t tbl [12];

    always #5 clk = ~clk;

    smpl_queue #(.DEPTH(8), .RD_LEN(5), .W(SW)) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrt_smpl   (wr_s),
        .lft_in     (lin_s),
        .rght_in    (rin_s),
        .lft_out    (lout_s),
        .rght_out   (rout_s),
        .sequencing (seq_s),
        .drop_err   (derr_s)
    );

    smpl_queue dut_d (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrt_smpl   (wr_d),
        .lft_in     (lin_d),
        .rght_in    (rin_d),
        .lft_out    (lout_d),
        .rght_out   (rout_d),
        .sequencing (seq_d),
        .drop_err   (derr_d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_s(input logic [SW-1:0] v);
        wr_s  = 1'b1;
        lin_s = v;
        rin_s = v + 24'd100;
        step();
        wr_s  = 1'b0;
    endtask

    // Called right after the triggering write edge T.
    task automatic expect_stream(input logic [SW-1:0] first);
        check("seq_at_T", seq_s, 0);
        step();
        check("seq_at_T1", seq_s, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("seq_on", seq_s, 1);
            check("lft_stream", lout_s, first + k);
            check("rght_stream", rout_s, first + k + 100);
        end
        step();
        check("seq_off", seq_s, 0);
        check("lft_hold", lout_s, first + 4);
    endtask

    task automatic expect_quiet();
        for (int k = 0; k < 7; k++) begin
            check("seq_quiet", seq_s, 0);
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin
            tbl[i].val     = 24'(i + 1);
            tbl[i].streams = (i >= 4);
            tbl[i].first   = (i >= 4) ? 24'(i - 3) : 24'd0;
        end

        rst_n = 1'b0;
        wr_s = 1'b0; lin_s = '0; rin_s = '0;
        wr_d = 1'b0; lin_d = '0; rin_d = '0;
        step();
        step();
        check("rst_seq_s", seq_s, 0);
        check("rst_lft_s", lout_s, 0);
        check("rst_rght_s", rout_s, 0);
        check("rst_derr_s", derr_s, 0);
        check("rst_seq_d", seq_d, 0);
        check("rst_lft_d", lout_d, 0);
        rst_n = 1'b1;
        step();

        // Fill, steady state and wrap (write 12 lands at addr 3, window 7,0..3)
        for (int i = 0; i < 12; i++) begin
            write_s(tbl[i].val);
            if (tbl[i].streams) expect_stream(tbl[i].first);
            else expect_quiet();
        end
        check("derr_clean", derr_s, 0);

        // Overlap: write 13 streams 9..13; write 14 arrives 2 clks into the sequence
        write_s(24'd13);
        check("ovl_seq_T", seq_s, 0);
        step();
        check("ovl_seq_T1", seq_s, 0);
        step();
        check("ovl_lft0", lout_s, 9);
        wr_s = 1'b1; lin_s = 24'd14; rin_s = 24'd114;
        step();
        wr_s = 1'b0;
        check("ovl_lft1", lout_s, 10);
        for (int k = 2; k < 5; k++) begin
            step();
            check("ovl_seq", seq_s, 1);
            check("ovl_lft", lout_s, 9 + k);
            check("ovl_rght", rout_s, 109 + k);
        end
        step();
        check("ovl_seq_off", seq_s, 0);
        check("ovl_derr", derr_s, 1);
        expect_quiet();
        check("ovl_derr_held", derr_s, 1);
        write_s(24'd15);
        expect_stream(24'd11);
        check("ovl_derr_sticky", derr_s, 1);

        // Reset in the middle of a sequence
        write_s(24'd16);
        step();
        step();
        check("mid_lft0", lout_s, 12);
        step();
        check("mid_lft1", lout_s, 13);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_seq", seq_s, 0);
        check("mid_rst_lft", lout_s, 0);
        check("mid_rst_rght", rout_s, 0);
        check("mid_rst_derr", derr_s, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int v = 20; v < 24; v++) begin
            write_s(24'(v));
            expect_quiet();
        end
        write_s(24'd24);
        expect_stream(24'd20);
        check("refill_derr", derr_s, 0);

        // Default sizing: 1021 back-to-back writes, then one 1021-cycle stream
        for (int i = 1; i <= 1021; i++) begin
            wr_d  = 1'b1;
            lin_d = 24'(i);
            rin_d = 24'(i + 100);
            step();
            check("def_fill_seq", seq_d, 0);
        end
        wr_d = 1'b0;
        step();
        check("def_seq_T1", seq_d, 0);
        for (int k = 0; k < 1021; k++) begin
            step();
            check("def_seq_on", seq_d, 1);
            check("def_lft", lout_d, k + 1);
            check("def_rght", rout_d, k + 101);
        end
        step();
        check("def_seq_off", seq_d, 0);
        check("def_lft_hold", lout_d, 1021);
        check("def_derr", derr_d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
